// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with a
// final sign-correction cycle. MTHI/MTLO write HI/LO directly from IDLE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an op; MT writes happen here
// RUN   | one radix-2 iteration per cycle, counter counts down to 0
// FIX   | sign correction, HI/LO write, done pulse

module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mf_req,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic               is_div, sign_q, sign_r;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    logic               md_op, mt_op, signed_op, accept_md, accept_mt;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign md_op     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign mt_op     = (op == OP_MTHI) || (op == OP_MTLO);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign accept_md = (state == IDLE) && start && !flush && md_op;
    assign accept_mt = (state == IDLE) && start && !flush && mt_op;
    assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

    // Multiply: the multiplier sits in the low half and shifts out LSB first.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: partial remainder in the high half, quotient bits enter at the LSB.
    assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    assign div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_fix = sign_q ? -acc : acc;
    assign quo_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept_md) state_d = RUN;
            RUN:     if (flush) state_d = IDLE;
                     else if (cnt == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Datapath, counter and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            opb    <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_d != IDLE);
            case (state)
                IDLE: begin
                    if (accept_md) begin
                        acc    <= {{WIDTH{1'b0}}, abs_a};
                        opb    <= abs_b;
                        is_div <= (op == OP_DIV) || (op == OP_DIVU);
                        sign_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r <= signed_op & a[WIDTH-1];
                        cnt    <= CNT_W'(WIDTH - 1);
                    end else if (accept_mt) begin
                        if (op == OP_MTHI) hi_q <= a;
                        else               lo_q <= a;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        acc <= is_div ? div_next : mul_next;
                        if (cnt != '0) cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign stall = busy_q & (start | mf_req);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: the driver pushes reference results
// when an op is accepted, the monitor pops and compares on each done pulse.

module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, mf_req, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, stall, done;

    int vectors = 0;
    int miscompares = 0;
    int done_count = 0;
    logic [63:0] sb[$];
    logic [31:0] model_hi = '0, model_lo = '0;

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mf_req(mf_req), .flush(flush), .hi(hi), .lo(lo),
        .busy(busy), .stall(stall), .done(done)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = '0;
        case (o)
            3'd1: res = sx * sy;
            3'd2: res = {32'd0, x} * {32'd0, y};
            3'd3: begin
                if (y == 0) res = {x, (x[31] ? 32'h00000001 : 32'hFFFFFFFF)};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (y == 0) res = {x, 32'hFFFFFFFF};
                else        res = {x % y, x / y};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_count++;
            check("busy_at_done", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("hi_lo_result", {hi, lo}, e);
                model_hi = e[63:32];
                model_lo = e[31:0];
            end
        end
    end

    task automatic idle_inputs();
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
    endtask

    // Present an op at a negedge and hold it until the unit accepts it.
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input bit push, output int waits);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        waits = 0;
        #1;
        while (stall && waits < 200) begin
            waits++;
            @(negedge clk);
            #1;
        end
        if (stall) check("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        if (push && o >= 3'd1 && o <= 3'd4) sb.push_back(ref_model(o, va, vb));
        if (o == 3'd5) model_hi = va;
        if (o == 3'd6) model_lo = va;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w, cnt, d0;
        logic [63:0] e;
        rst = 1'b1; mf_req = 1'b0; flush = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-RUN discards the op and clears HI/LO.
        issue(3'd5, 32'hAAAA5555, 32'd0, 1'b0, w);
        issue(3'd6, 32'h5555AAAA, 32'd0, 1'b0, w);
        issue(3'd1, 32'd3, 32'd5, 1'b0, w);
        idle_inputs();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_hi = '0; model_lo = '0;
        sb.delete();
        check("rst_mid_hi", {32'd0, hi}, 64'd0);
        check("rst_mid_lo", {32'd0, lo}, 64'd0);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        d0 = done_count;
        repeat (40) @(negedge clk);
        check("rst_mid_no_done", 64'(done_count), 64'(d0));

        // MULT -3*5 with busy-length measurement.
        issue(3'd1, 32'hFFFFFFFD, 32'd5, 1'b1, w);
        idle_inputs();
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("mult_busy_cycles", 64'(cnt), 64'd33);
        check("mult_done_after_busy", {63'd0, done}, 64'd1);
        wait_drain();
        check("mult_hi_lo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

        issue(3'd2, 32'hFFFFFFFD, 32'd5, 1'b1, w); idle_inputs(); wait_drain();
        check("multu_hi_lo", {hi, lo}, 64'h00000004_FFFFFFF1);
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, w); idle_inputs(); wait_drain();
        check("div_hi_lo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        issue(3'd4, 32'd7, 32'd0, 1'b1, w); idle_inputs(); wait_drain();
        check("divu_by0_hi_lo", {hi, lo}, 64'h00000007_FFFFFFFF);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, w); idle_inputs(); wait_drain();
        check("div_ovf_hi_lo", {hi, lo}, 64'h00000000_80000000);
        issue(3'd3, 32'hFFFFFFF9, 32'd0, 1'b1, w); idle_inputs(); wait_drain();
        check("div_by0_neg", {hi, lo}, 64'hFFFFFFF9_00000001);

        // Back-to-back DIVU held on the inputs.
        issue(3'd4, 32'd100, 32'd7, 1'b1, w);
        issue(3'd4, 32'd100, 32'd7, 1'b1, w);
        check("b2b_stall_cycles", 64'(w), 64'd33);
        idle_inputs();
        wait_drain();
        check("b2b_hi_lo", {hi, lo}, 64'h00000002_0000000E);

        // MTHI in IDLE.
        issue(3'd5, 32'h12345678, 32'd0, 1'b1, w);
        idle_inputs();
        check("mthi_hi", {32'd0, hi}, 64'h12345678);
        check("mthi_lo_kept", {32'd0, lo}, {32'd0, model_lo});
        check("mthi_busy", {63'd0, busy}, 64'd0);

        // mf_req 10 cycles into a MULT.
        e = ref_model(3'd1, 32'h00012345, 32'hFFFF0001);
        issue(3'd1, 32'h00012345, 32'hFFFF0001, 1'b1, w);
        idle_inputs();
        repeat (10) @(negedge clk);
        mf_req = 1'b1;
        cnt = 0;
        forever begin
            #1;
            if (!stall || cnt >= 100) break;
            cnt++;
            @(negedge clk);
        end
        check("mf_stall_cycles", 64'(cnt), 64'd23);
        check("mf_release_on_done", {63'd0, done}, 64'd1);
        check("mf_sees_new_hi_lo", {hi, lo}, e);
        @(negedge clk);
        mf_req = 1'b0;
        wait_drain();

        // Flush at RUN cycle 5 of MULTU.
        d0 = done_count;
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, w);
        idle_inputs();
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_hi_lo_kept", {hi, lo}, {model_hi, model_lo});
        check("flush_no_done", 64'(done_count), 64'(d0));

        // start together with flush is ignored.
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5; flush = 1'b1;
        @(negedge clk);
        check("sflush_busy", {63'd0, busy}, 64'd0);
        op = 3'd5; a = 32'hDEADBEEF;
        @(negedge clk);
        flush = 1'b0;
        idle_inputs();
        check("sflush_mthi_ignored", {32'd0, hi}, {32'd0, model_hi});
        repeat (40) @(negedge clk);
        check("sflush_no_done", 64'(done_count), 64'(d0));

        // Randomized ops, sometimes back-to-back.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] va, vb;
            o  = 3'($urandom_range(1, 6));
            va = pick();
            vb = pick();
            issue(o, va, vb, 1'b1, w);
            if (o == 3'd5) check("rand_mthi", {hi, lo}, {va, model_lo});
            if (o == 3'd6) check("rand_mtlo", {hi, lo}, {model_hi, va});
            if ($urandom_range(0, 1) == 0) begin
                idle_inputs();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        idle_inputs();
        wait_drain();
        check("final_queue_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
